// File: rtl/pipelined_add_sub_if.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub_if
//   Handshake bundle for the pipelined adder/subtractor.
//   Request side : in_valid/in_ready with operands a, b and op select sub.
//   Response side: out_valid/out_ready with sum and the carry/overflow/zero
//                  flags.
//   Modports:
//     master - the producer/consumer around the block (drives the request and
//              out_ready, observes the response)
//     slave  - the adder itself
// -----------------------------------------------------------------------------
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub
//   Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is
//   cut into STAGES chunks of CHUNK = ceil(WIDTH/STAGES) bits; stage k adds
//   chunk k plus the carry registered by stage k-1, so a result emerges exactly
//   STAGES cycles after it is accepted. One operation per cycle is accepted and
//   the whole pipeline freezes while the consumer stalls.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth / number of carry-chain chunks (1..WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards everything in flight
//   bus    pipelined_add_sub_if.slave:
//            in_valid/in_ready, a, b, sub      request (sub=1 -> A + ~B + 1)
//            out_valid/out_ready, sum          response (sum wraps mod 2^WIDTH)
//            carry_out  carry from the MSB (for sub: 1 = no borrow)
//            overflow   signed overflow of the selected operation
//            zero       sum == 0
//          flags are meaningful only while out_valid = 1.
//
// Configuration
//   SATURATE_EN  when defined, an overflowing result is clamped to the signed
//                extreme in the direction of A (0x7F..F for A >= 0, 0x80..0
//                for A < 0). overflow still reports 1 and zero is taken from
//                the clamped value. Undefined: the sum simply wraps.
// -----------------------------------------------------------------------------
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_add_sub_if.slave  bus
);

  // Every chunk is CHUNK bits wide. When WIDTH is not a multiple of STAGES the
  // operands are zero-padded up to PW bits, so the top chunk effectively holds
  // only the remainder; its padding bits just propagate the MSB carry upward.
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
  localparam int PW    = CHUNK * STAGES;
  // Registers between stages; stage STAGES-1 writes the output registers
  // directly, so a single-stage build needs none (one dummy slot is kept).
  localparam int PIPE  = (STAGES > 1) ? STAGES - 1 : 1;
  // With padding the MSB carry lands in bit WIDTH of the padded sum.
  localparam int CIDX  = (PW > WIDTH) ? WIDTH : PW - 1;

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // State carried by one pipeline slot. Operand bits above the current chunk
  // are still needed downstream; sum bits below it are already final. B is
  // stored pre-inverted for subtraction, so no stage needs to know the op.
  typedef struct packed {
    logic          valid;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic [PW-1:0] s;
    logic          c;
  } stage_t;

  stage_t st_in [STAGES];   // what each stage sees this cycle
  stage_t st_d  [STAGES];   // what each stage would register
  stage_t st_q  [PIPE];     // inter-stage registers

  logic [PW-1:0]    a_pad;
  logic [PW-1:0]    b_pad;
  logic             advance;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             carry_out_d, carry_out_q;
  logic             overflow_d,  overflow_q;
  logic             zero_d,      zero_q;

  // ---------------------------------------------------------------------------
  // Flow control: the pipeline moves as one unit whenever the output slot is
  // empty or being drained this cycle. A full pipeline with out_ready=1 takes
  // a new operation and hands one out in the same cycle.
  // ---------------------------------------------------------------------------
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage inputs: stage 0 takes the request (carry-in = sub completes the
  // two's-complement negation of B), later stages take the previous register.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a full default before
  // any partial or conditional update; otherwise a latch is inferred.
  always_comb begin
    a_pad = '0;
    a_pad[WIDTH-1:0] = bus.a;
    b_pad = '0;
    b_pad[WIDTH-1:0] = bus.sub ? ~bus.b : bus.b;

    st_in[0] = '{valid: bus.in_valid, a: a_pad, b: b_pad, s: '0, c: bus.sub};
    for (int k = 1; k < STAGES; k++) begin
      st_in[k] = st_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk adders: stage k resolves bits [k*CHUNK +: CHUNK] and produces the
  // carry that stage k+1 will consume one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [CHUNK:0] part;
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, st_in[k].a[k*CHUNK +: CHUNK]}
           + {1'b0, st_in[k].b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, st_in[k].c};
      st_d[k]                     = st_in[k];
      st_d[k].s[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      st_d[k].c                   = part[CHUNK];
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: derive flags (and the optional clamp) from the completed sum
  // so they are registered together with it and latency stays STAGES.
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_t           last;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic             a_msb;
    logic             bp_msb;
    logic             ovf;

    last    = st_d[STAGES-1];
    sum_raw = last.s[WIDTH-1:0];
    a_msb   = last.a[WIDTH-1];
    bp_msb  = last.b[WIDTH-1];
    // Same-sign operands (after B inversion) whose sum flips sign overflowed.
    ovf     = (a_msb == bp_msb) && (sum_raw[WIDTH-1] != a_msb);

`ifdef SATURATE_EN
    // Overflow can only happen towards the sign of A, so A picks the extreme.
    if (ovf) begin
      sum_fin = a_msb ? SMIN : SMAX;
    end else begin
      sum_fin = sum_raw;
    end
`else
    sum_fin = sum_raw;
`endif

    out_valid_d = last.valid;
    sum_d       = sum_fin;
    carry_out_d = (PW > WIDTH) ? last.s[CIDX] : last.c;
    overflow_d  = ovf;
    zero_d      = (sum_fin == '0);
  end

  // ---------------------------------------------------------------------------
  // Registers. Nothing moves unless the pipeline advances, which keeps the
  // outputs stable during a stall.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only the valid bits matter for correctness, but the stage data
      // is a handful of plain registers (not a memory array), so it is cleared
      // too and never carries X through the datapath after reset.
      for (int k = 0; k < PIPE; k++) begin
        st_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        st_q[k] <= st_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
